// File: rtl/stage_cntrl_pkg.sv
// Shared encodings for the stage sequencer: state codes, opcodes, decode helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package stage_cntrl_pkg;

  // Sequencer state encodings, visible on the stage output.
  localparam logic [2:0] STG_IDLE       = 3'd0;
  localparam logic [2:0] STG_FETCH      = 3'd1;
  localparam logic [2:0] STG_DECODE     = 3'd2;
  localparam logic [2:0] STG_EXECUTE    = 3'd3;
  localparam logic [2:0] STG_WRITE_BACK = 3'd4;
  localparam logic [2:0] STG_HALT       = 3'd5;

  // Opcode field values (inst[31:27]).
  localparam logic [4:0] OP_MOV  = 5'h01;
  localparam logic [4:0] OP_CMP  = 5'h02;
  localparam logic [4:0] OP_BR   = 5'h03;
  localparam logic [4:0] OP_HALT = 5'h1F;

  // How the sequencer treats an opcode; anything unknown is an ordinary ALU op.
  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_BRANCH = 2'd1,
    OPC_HALT   = 2'd2
  } op_class_e;

  // Write-back strobe bundle.
  typedef struct packed {
    logic pc_enable;
    logic reg_write_en;
    logic take_branch;
  } wb_strobe_t;

  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e c;
    case (op)
      OP_HALT:        c = OPC_HALT;
      OP_BR:          c = OPC_BRANCH;
      OP_MOV, OP_CMP: c = OPC_ALU;
      default:        c = OPC_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stage_cntrl_if.sv
// Bundle of the sequencer's datapath-facing signals (fetch handshake, execute busy, strobes, status).
// Latency: n/a (wires only).
// Backpressure: imem_ack and alu_busy stall the sequencer; master = sequencer, slave = datapath.
interface stage_cntrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             imem_req;
  logic             imem_ack;
  logic             inst_latch_en;
  logic [4:0]       opcode;
  logic             alu_busy;
  logic             pc_enable;
  logic             reg_write_en;
  logic             take_branch;
  logic [2:0]       stage;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  run, imem_ack, opcode, alu_busy,
    output imem_req, inst_latch_en, pc_enable, reg_write_en, take_branch,
           stage, halted, fault, retired_count, stall_count
  );

  modport slave (
    output run, imem_ack, opcode, alu_busy,
    input  imem_req, inst_latch_en, pc_enable, reg_write_en, take_branch,
           stage, halted, fault, retired_count, stall_count
  );
endinterface

// File: rtl/stage_cntrl_perf_cnt.sv
// Free-running event counter with enable, wrapping modulo 2^W.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; counts every enabled cycle.
module stage_cntrl_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles; overflow simply wraps to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stage_cntrl.sv
// Multi-cycle CPU stage sequencer: IDLE/FETCH/DECODE/EXECUTE/WRITE_BACK/HALT with fetch timeout.
// Latency: 4 cycles minimum per instruction, back-to-back with no bubble while run=1.
// Backpressure: holds FETCH until imem_ack, EXECUTE while alu_busy; optional perf counters under STAGE_CNTRL_PERF_EN.
module stage_cntrl
  import stage_cntrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic          clk,
  input  logic          reset,
  stage_cntrl_if.master bus
);

  // Wait counter only needs to hold 0 .. FETCH_TIMEOUT-1; the last value triggers the timeout.
  localparam bit         TIMEOUT_EN  = (FETCH_TIMEOUT != 0);
  localparam int         WAIT_W      = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam int         WAIT_LAST_I = TIMEOUT_EN ? (FETCH_TIMEOUT - 1) : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic              is_br_q, is_br_d;

  op_class_e         cls;
  logic              fetch_wait;
  logic              timeout_hit;
  wb_strobe_t        wb;

  assign cls         = classify(bus.opcode);
  assign fetch_wait  = (state_q == STG_FETCH) && !bus.imem_ack;
  assign timeout_hit = TIMEOUT_EN && fetch_wait && (wait_q == WAIT_LAST);

  // Next-state and bookkeeping; ack is checked before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    is_br_d = is_br_q;
    case (state_q)
      STG_IDLE: begin
        if (bus.run) begin
          state_d = STG_FETCH;
          wait_d  = '0;
        end
      end
      STG_FETCH: begin
        if (bus.imem_ack) begin
          state_d = STG_DECODE;
        end else if (timeout_hit) begin
          state_d = STG_HALT;
          fault_d = 1'b1;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      STG_DECODE: begin
        // The instruction register is stable until the next fetch, so the branch
        // decision is captured here and write-back strobes come purely from flops.
        is_br_d = (cls == OPC_BRANCH);
        state_d = (cls == OPC_HALT) ? STG_HALT : STG_EXECUTE;
      end
      STG_EXECUTE: begin
        if (!bus.alu_busy) begin
          state_d = STG_WRITE_BACK;
        end
      end
      STG_WRITE_BACK: begin
        // Run is only honoured at an instruction boundary; dropping it mid-instruction
        // lets the current one finish and parks here into IDLE.
        if (bus.run) begin
          state_d = STG_FETCH;
          wait_d  = '0;
        end else begin
          state_d = STG_IDLE;
        end
      end
      STG_HALT: begin
        state_d = STG_HALT;
      end
      default: begin
        state_d = STG_IDLE;
      end
    endcase
  end

  // State registers; reset drops everything (and thus every Moore strobe) at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STG_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
      is_br_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      is_br_q <= is_br_d;
    end
  end

  assign wb = '{
    pc_enable:    (state_q == STG_WRITE_BACK),
    reg_write_en: (state_q == STG_WRITE_BACK) && !is_br_q,
    take_branch:  (state_q == STG_WRITE_BACK) &&  is_br_q
  };

  assign bus.imem_req      = (state_q == STG_FETCH);
  assign bus.inst_latch_en = (state_q == STG_FETCH) && bus.imem_ack;
  assign bus.pc_enable     = wb.pc_enable;
  assign bus.reg_write_en  = wb.reg_write_en;
  assign bus.take_branch   = wb.take_branch;
  assign bus.stage         = state_q;
  assign bus.halted        = (state_q == STG_HALT);
  assign bus.fault         = fault_q;

`ifdef STAGE_CNTRL_PERF_EN
  logic retire_ev;
  logic stall_ev;

  assign retire_ev = (state_q == STG_WRITE_BACK);
  assign stall_ev  = fetch_wait || ((state_q == STG_EXECUTE) && bus.alu_busy);

  stage_cntrl_perf_cnt #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retire_ev),
    .count (bus.retired_count)
  );

  stage_cntrl_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_ev),
    .count (bus.stall_count)
  );
`else
  assign bus.retired_count = '0;
  assign bus.stall_count   = '0;
`endif

endmodule

// File: tb/tb_stage_cntrl.sv
// Self-checking bench for stage_cntrl: instruction-level scenarios expanded into a cycle timeline.
// Latency: n/a.
// Backpressure: random imem_ack delays and alu_busy lengths.
module tb_stage_cntrl;
  import stage_cntrl_pkg::*;

  localparam int CNT_W = 32;
  localparam int TMO   = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                         S_EXE  = 3'd3, S_WB    = 3'd4, S_HALT = 3'd5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stage_cntrl_if #(.CNT_W(CNT_W)) bus ();

  stage_cntrl #(.FETCH_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One cycle of the expected timeline: inputs to drive and the stage the
  // controller must be in during that cycle.
  typedef struct {
    logic [2:0] stg;
    logic       run;
    logic       ack;
    logic       busy;
    logic [4:0] op;
    logic       flt;
  } cyc_t;

  cyc_t tl[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [CNT_W-1:0] exp_ret;
  logic [CNT_W-1:0] exp_stall;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rop();
    logic [4:0] v;
    case ($urandom_range(0, 3))
      0:       v = OP_MOV;
      1:       v = OP_CMP;
      2:       v = OP_BR;
      default: begin
        v = 5'($urandom);
        if (v == OP_HALT) v = OP_MOV;
      end
    endcase
    return v;
  endfunction

  task automatic push(input logic [2:0] stg, input logic run, input logic ack,
                      input logic busy, input logic [4:0] op, input logic flt);
    cyc_t c;
    c.stg = stg; c.run = run; c.ack = ack; c.busy = busy; c.op = op; c.flt = flt;
    tl.push_back(c);
  endtask

  // One instruction starting in FETCH: d cycles without ack, b busy execute
  // cycles, run value r presented at write-back.
  task automatic gen_instr(input logic [4:0] op, input int d, input int b, input logic r);
    for (int j = 0; j < d; j++) push(S_FETCH, rbit(), 1'b0, rbit(), op, 1'b0);
    push(S_FETCH, rbit(), 1'b1, rbit(), op, 1'b0);
    push(S_DEC, rbit(), rbit(), rbit(), op, 1'b0);
    if (op == OP_HALT) begin
      for (int j = 0; j < 3; j++) push(S_HALT, rbit(), rbit(), rbit(), rop(), 1'b0);
      return;
    end
    for (int j = 0; j < b; j++) push(S_EXE, rbit(), rbit(), 1'b1, op, 1'b0);
    push(S_EXE, rbit(), rbit(), 1'b0, op, 1'b0);
    push(S_WB, r, rbit(), rbit(), op, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) push(S_IDLE, 1'b0, rbit(), rbit(), rop(), 1'b0);
  endtask

  // Drive the timeline cycle by cycle and compare against the rules of each stage.
  task automatic replay();
    foreach (tl[i]) begin
      logic [6:0] exp_o, got_o;
      bus.run      = tl[i].run;
      bus.imem_ack = tl[i].ack;
      bus.alu_busy = tl[i].busy;
      bus.opcode   = tl[i].op;
      #1;
      exp_o = {tl[i].stg == S_FETCH,
               (tl[i].stg == S_FETCH) && tl[i].ack,
               tl[i].stg == S_WB,
               (tl[i].stg == S_WB) && (tl[i].op != OP_BR),
               (tl[i].stg == S_WB) && (tl[i].op == OP_BR),
               tl[i].stg == S_HALT,
               tl[i].flt};
      got_o = {bus.imem_req, bus.inst_latch_en, bus.pc_enable, bus.reg_write_en,
               bus.take_branch, bus.halted, bus.fault};
      chk_eq("stage", 64'(bus.stage), 64'(tl[i].stg));
      chk_eq("strobes", 64'(got_o), 64'(exp_o));
`ifdef STAGE_CNTRL_PERF_EN
      chk_eq("retired", 64'(bus.retired_count), 64'(exp_ret));
      chk_eq("stall", 64'(bus.stall_count), 64'(exp_stall));
`else
      chk_eq("retired", 64'(bus.retired_count), 64'd0);
      chk_eq("stall", 64'(bus.stall_count), 64'd0);
`endif
      if (tl[i].stg == S_WB) exp_ret = exp_ret + 1'b1;
      if (((tl[i].stg == S_FETCH) && !tl[i].ack) || ((tl[i].stg == S_EXE) && tl[i].busy))
        exp_stall = exp_stall + 1'b1;
      @(posedge clk);
      #1;
    end
    tl.delete();
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic do_reset();
    logic [6:0] got_o;
    reset        = 1'b0;
    bus.run      = 1'b0;
    bus.imem_ack = 1'b0;
    bus.alu_busy = 1'b0;
    bus.opcode   = 5'd0;
    #1;
    got_o = {bus.imem_req, bus.inst_latch_en, bus.pc_enable, bus.reg_write_en,
             bus.take_branch, bus.halted, bus.fault};
    chk_eq("rst_stage", 64'(bus.stage), 64'd0);
    chk_eq("rst_outputs", 64'(got_o), 64'd0);
    chk_eq("rst_counters", {bus.retired_count, bus.stall_count}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    exp_ret   = '0;
    exp_stall = '0;
  endtask

  initial begin
    bus.run = 1'b0; bus.imem_ack = 1'b0; bus.alu_busy = 1'b0; bus.opcode = 5'd0;
    exp_ret = '0; exp_stall = '0;

    // Minimum-latency MOVs back to back, then park.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    gen_instr(OP_MOV, 0, 0, 1'b1);
    gen_instr(OP_MOV, 0, 0, 1'b0);
    idle_cycles(2);
    replay();

    // Branch with a 4-cycle execute.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_BR, 1'b0);
    gen_instr(OP_BR, 0, 3, 1'b0);
    idle_cycles(1);
    replay();

    // Run dropped mid-instruction, later restarted; ack arrives on the last allowed cycle.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_CMP, 1'b0);
    for (int j = 0; j < 3; j++) push(S_FETCH, 1'b0, 1'b0, 1'b0, OP_CMP, 1'b0);
    push(S_FETCH, 1'b0, 1'b1, 1'b0, OP_CMP, 1'b0);
    push(S_DEC, 1'b0, 1'b0, 1'b0, OP_CMP, 1'b0);
    push(S_EXE, 1'b0, 1'b1, 1'b1, OP_CMP, 1'b0);
    push(S_EXE, 1'b0, 1'b0, 1'b0, OP_CMP, 1'b0);
    push(S_WB, 1'b0, 1'b0, 1'b0, OP_CMP, 1'b0);
    idle_cycles(2);
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    gen_instr(OP_MOV, TMO - 1, 0, 1'b0);
    idle_cycles(1);
    replay();

    // Fetch timeout: ack withheld for the full window, later acks ignored.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    for (int j = 0; j < TMO; j++) push(S_FETCH, rbit(), 1'b0, rbit(), OP_MOV, 1'b0);
    for (int j = 0; j < 4; j++) push(S_HALT, rbit(), 1'b1, rbit(), rop(), 1'b1);
    replay();

    // HALT opcode after one retired instruction.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    gen_instr(OP_MOV, 1, 0, 1'b1);
    gen_instr(OP_HALT, 0, 0, 1'b0);
    replay();

    // Randomized programs.
    for (int p = 0; p < 30; p++) begin
      int n;
      do_reset();
      idle_cycles($urandom_range(0, 2));
      push(S_IDLE, 1'b1, rbit(), rbit(), rop(), 1'b0);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        logic [4:0] op;
        logic       r;
        int         d;
        op = ((k == n - 1) && ($urandom_range(0, 4) == 0)) ? OP_HALT : rop();
        d  = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 4));
        r  = (k == n - 1) ? rbit() : 1'($urandom_range(0, 3) != 0);
        gen_instr(op, d, $urandom_range(0, 4), r);
        if (op == OP_HALT) break;
        if (!r) begin
          idle_cycles($urandom_range(1, 3));
          if (k != n - 1) push(S_IDLE, 1'b1, rbit(), rbit(), rop(), 1'b0);
        end
      end
      replay();
    end

    // Reset during EXECUTE takes effect without a clock edge.
    do_reset();
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    push(S_FETCH, 1'b1, 1'b1, 1'b0, OP_MOV, 1'b0);
    push(S_DEC, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    push(S_EXE, 1'b1, 1'b0, 1'b1, OP_MOV, 1'b0);
    replay();
    bus.alu_busy = 1'b1;
    #1;
    chk_eq("pre_rst_stage", 64'(bus.stage), 64'(S_EXE));
    do_reset();

    // Reset during WRITE_BACK drops the strobes immediately.
    push(S_IDLE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    push(S_FETCH, 1'b1, 1'b1, 1'b0, OP_MOV, 1'b0);
    push(S_DEC, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    push(S_EXE, 1'b1, 1'b0, 1'b0, OP_MOV, 1'b0);
    replay();
    #1;
    chk_eq("pre_rst_wb", 64'({bus.pc_enable, bus.reg_write_en}), 64'd3);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
